// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side handshake bundle between uart_rx and its consumer.
// master drives rx_data/rx_valid/rx_busy/frame_err/overrun, slave drives rx_ready.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, mid-bit sampling, one-entry holding register.
// Ports: clk, rst (async high), rx pin, baud_div (bit period - 1), bus (master).
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [15:0] baud_div,
  uart_rx_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rx_s;

  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        fe_q, fe_d;
  logic        ov_q, ov_d;
  logic        good;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    good    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // edge detect: a line held low after a break never re-arms
        if (prev_q && !rx_s) begin
          state_d = S_START;
          div_d   = baud_div;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == {1'b0, div_q[15:1]}) begin
          cnt_d = '0;
          if (!rx_s) state_d = S_DATA;
          else       state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == div_q) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = '0;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        // leave immediately so a back-to-back start bit is seen
        if (cnt_q == div_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (rx_s) good = 1'b1;
          else      fe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (valid_q && bus.rx_ready) valid_d = 1'b0;

    // a drain in the same cycle frees the slot for the new byte
    if (good) begin
      if (!valid_q || bus.rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.rx_busy   = (state_q != S_IDLE);
  assign bus.frame_err = fe_q;
  assign bus.overrun   = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at baud_div = 15.
// Frames are driven on the falling clock edge; results sampled off-edge.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [15:0] baud_div = 16'd15;

  uart_rx_if u ();

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .baud_div (baud_div),
    .bus      (u)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] q[$];
  int   fe_n;
  int   ov_n;
  int   vrise_n;
  bit   busy_seen;
  logic v_prev = 1'b0;

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (u.rx_valid && u.rx_ready) q.push_back(u.rx_data);
      if (u.frame_err) fe_n++;
      if (u.overrun) ov_n++;
      if (u.rx_valid && !v_prev) vrise_n++;
      if (u.rx_busy) busy_seen = 1'b1;
    end
    v_prev = u.rx_valid;
  end

  task automatic clr();
    q.delete();
    fe_n      = 0;
    ov_n      = 0;
    vrise_n   = 0;
    busy_seen = 1'b0;
  endtask

  // one frame, 16 clocks per bit, starting at the current negedge
  task automatic send(input logic [7:0] d, input logic stp = 1'b1);
    logic [9:0] f;
    f = {stp, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (16) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic drain();
    u.rx_ready = 1'b1;
    @(negedge clk);
    u.rx_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  logic [7:0] b2b[3];

  initial begin
    u.rx_ready = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", u.rx_valid, 0);
    check("rst_data", u.rx_data, 8'h00);
    check("rst_busy", u.rx_busy, 0);
    check("rst_fe", u.frame_err, 0);
    check("rst_ov", u.overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // single byte; stop sample lands on posedge 155 after the start fall
    clr();
    fork
      send(8'h55);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        #1;
        check("pre_stop_busy", u.rx_busy, 1);
        check("pre_stop_valid", u.rx_valid, 0);
        @(negedge clk);
        #1;
        check("post_stop_busy", u.rx_busy, 0);
        check("post_stop_valid", u.rx_valid, 1);
      end
    join
    repeat (4) @(negedge clk);
    check("single_data", u.rx_data, 8'h55);
    check("single_vrise", vrise_n, 1);
    check("single_fe", fe_n, 0);
    drain();
    check("drain_valid", u.rx_valid, 0);
    check("drain_q", q.size() > 0 ? q[0] : 8'hxx, 8'h55);

    // back-to-back with consumer always ready
    clr();
    u.rx_ready = 1'b1;
    send(8'h00);
    send(8'hFF);
    send(8'hA5);
    repeat (20) @(negedge clk);
    u.rx_ready = 1'b0;
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'hA5;
    check("b2b_count", q.size(), 3);
    for (int i = 0; i < 3; i++)
      check("b2b_byte", q.size() > i ? q[i] : 8'hxx, b2b[i]);
    check("b2b_ov", ov_n, 0);
    check("b2b_fe", fe_n, 0);

    // 3-clock glitch
    repeat (5) @(negedge clk);
    clr();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy", u.rx_busy, 0);
    check("glitch_vrise", vrise_n, 0);
    check("glitch_fe", fe_n, 0);

    // bad stop bit
    clr();
    send(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_pulses", fe_n, 1);
    check("ferr_vrise", vrise_n, 0);
    check("ferr_valid", u.rx_valid, 0);

    // break: 30 bit times low
    clr();
    rx = 1'b0;
    repeat (30 * 16) @(negedge clk);
    check("break_fe", fe_n, 1);
    check("break_vrise", vrise_n, 0);
    check("break_busy", u.rx_busy, 0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("break_idle", u.rx_busy, 0);
    send(8'h5A);
    repeat (5) @(negedge clk);
    check("rearm_valid", u.rx_valid, 1);
    check("rearm_data", u.rx_data, 8'h5A);
    drain();

    // overrun with nobody draining
    clr();
    send(8'h11);
    send(8'h22);
    repeat (10) @(negedge clk);
    check("ovr_data", u.rx_data, 8'h11);
    check("ovr_pulses", ov_n, 1);
    check("ovr_valid", u.rx_valid, 1);
    drain();

    // drain exactly on the completion cycle of the second byte
    clr();
    send(8'h11);
    fork
      send(8'h22);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        u.rx_ready = 1'b1;
        @(negedge clk);
        u.rx_ready = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    check("same_cyc_data", u.rx_data, 8'h22);
    check("same_cyc_ov", ov_n, 0);
    check("same_cyc_valid", u.rx_valid, 1);
    check("same_cyc_q", q.size() > 0 ? q[0] : 8'hxx, 8'h11);

    // reset during data bit 4, holding register still full of 0x22
    clr();
    fork
      send(8'hFF);
      begin
        repeat (16 * 5 + 8) @(negedge clk);
        #1;
        check("mid_busy", u.rx_busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", u.rx_valid, 0);
        check("mid_rst_data", u.rx_data, 8'h00);
        check("mid_rst_busy", u.rx_busy, 0);
        check("mid_rst_fe", u.frame_err, 0);
        check("mid_rst_ov", u.overrun, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    clr();
    send(8'h81);
    repeat (5) @(negedge clk);
    check("post_rst_valid", u.rx_valid, 1);
    check("post_rst_data", u.rx_data, 8'h81);
    check("post_rst_fe", fe_n, 0);
    check("post_rst_ov", ov_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserialises 8N1 frames from the `rx` pin into bytes. It is the receive-side counterpart of the team's UART transmitter and shares its `baud_div` programming: one bit period is `baud_div + 1` clocks. It sits between the pad and the peripheral register/FIFO layer. It provides a two-flop synchroniser, mid-bit sampling, a one-entry output holding register with a valid/ready handshake, and framing and overrun reporting.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth on `rx`; minimum 2.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `rx`  in  1  serial input; asynchronous to `clk`; idles high
- `baud_div`  in  16  bit period minus one, in clocks; supported range 3..65535
- `rx_data`  out  8  received byte, valid while `rx_valid` is 1
- `rx_valid`  out  1  holding register full
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid & rx_ready`
- `rx_busy`  out  1  FSM is not in IDLE
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `overrun`  out  1  one-cycle pulse: a byte completed while the holding register was full and not being drained

## Operation
- Synchroniser: `SYNC_STAGES` flops reset to 1. The synchronised value `rx_s` is also registered as `rx_prev`, which resets to 1.
- FSM states are IDLE, START, DATA and STOP.
  - IDLE → START when `rx_prev == 1 && rx_s == 0` (falling edge). On this transition, `baud_div` is latched into `div_q`, and `cnt` and `bit_idx` are set to 0.
  - START: `cnt` counts up. At `cnt == div_q >> 1`, the FSM samples `rx_s`:
    - 0 → DATA, with `cnt` set to 0.
    - 1 → IDLE. This is a false start: no flag is raised.
  - DATA: at `cnt == div_q`, the FSM shifts `rx_s` into the MSB of `shift_q` (LSB-first line order), sets `cnt` to 0 and increments `bit_idx`. Otherwise it increments `cnt`. After the 8th sample (`bit_idx == 7` at sample time) it goes to STOP.
  - STOP: at `cnt == div_q`, the FSM samples `rx_s` and returns to IDLE in that same cycle, so it can catch a start bit that follows immediately.
    - Sample 1: the byte is good.
    - Sample 0: `frame_err` pulses for one cycle. The byte is discarded and `rx_valid` is unaffected.
- Holding register, on the cycle a good byte completes:
  - If `rx_valid == 0`, or `rx_ready == 1` (the register is draining in the same cycle): load `rx_data` with `shift_q`; `rx_valid` is 1 next cycle.
  - If `rx_valid == 1 && rx_ready == 0`: keep the old `rx_data`, drop the new byte and pulse `overrun` for one cycle.
- `rx_valid` clears on the cycle after `rx_valid & rx_ready`, unless a new byte loads in that same cycle.
- Re-arm after a frame error: IDLE requires a new falling edge. A line stuck low (break) therefore produces a single `frame_err` and no further frames until `rx` returns high.
- A change on `baud_div` mid-frame has no effect until the next start detection.
- `rx_busy` = (state != IDLE).

## Timing
- Reset (asynchronous assertion, synchronous-safe release) sets:
  - state to IDLE, `rx_data` = 0x00, `rx_valid` = 0, `rx_busy` = 0, `frame_err` = 0, `overrun` = 0;
  - all synchroniser flops and `rx_prev` to 1.
  
  Reset mid-frame abandons the frame with no flag.
- Detection: with pin fall before clock edge E1 and `SYNC_STAGES` = 2, the state is START after edge E3. Call that edge D.
- Sample instants, with `h = div_q >> 1` and `P = div_q + 1`:
  - start bit: edge D + h + 1
  - data bit k (k = 0..7): edge D + h + 1 + (k+1)·P
  - stop bit: edge D + h + 1 + 9·P
- Completion registers: `rx_valid`, `frame_err` and `overrun` are updated by the stop-sample edge, so they are visible in the cycle following it.
- Tolerance: the sample point is mid-bit within ±1 clock. This accepts transmitter/receiver clock mismatch up to about ±4% at `baud_div ≥ 15`.
- Handshake: `rx_data` is stable while `rx_valid` is 1 and no transfer has occurred. There is no combinational path from `rx_ready` to `rx_valid`.

## Test plan
- **Single byte.** Inputs: `baud_div` = 15; frame 0x55 driven with exact timing; `rx_ready` = 0. Required: `rx_valid` rises once; `rx_data` = 0x55; `frame_err` = 0; `rx_busy` falls at mid-stop.
- **Back-to-back frames.** Inputs: 0x00, 0xFF, 0xA5 with no idle gap; `rx_ready` = 1. Required: three transfers in order; no `overrun`. Also drive the same bytes through the UART transmitter looped back to `rx` and check the same result.
- **Glitch.** Input: `rx` low for 3 clocks (`baud_div` = 15). Required: `rx_busy` rises then returns to 0 at the start check; no `rx_valid`; no `frame_err`.
- **Framing error and break.**
  - Frame 0x3C with a stop bit of 0: `frame_err` is a 1-cycle pulse; `rx_valid` stays 0.
  - `rx` held low for 30 bit times: exactly one `frame_err`, then idle until `rx` is high again.
- **Overrun.**
  - 0x11 then 0x22 with `rx_ready` = 0: `rx_data` = 0x11, `overrun` pulses once.
  - Repeat with `rx_ready` asserted exactly on the 0x22 completion cycle: `rx_data` = 0x22 and no `overrun`.
- **Reset mid-frame.** Input: assert `rst` during data bit 4, then send 0x81. Required: all outputs are at their reset values while `rst` is high; afterwards `rx_data` = 0x81 is received cleanly.
